// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [31:0]      i_datain,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic             o_done,
  output logic [WIDTH-1:0] c,
  output logic             c_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       zon
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             div_q, qneg_q, rneg_q;
  logic [WIDTH-1:0] a_raw_q, b_q, acc_q, mq_q;
  logic [WIDTH-1:0] hi_q, lo_q, c_q;
  logic [2:0]       zon_q;
  logic             done_q, cv_q;

  logic             op_md, op_mfhi, op_mflo;
  logic             op_mthi, op_mtlo;
  logic             sgn_op, s1, s2, go;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_df;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2:0]       res_zon;
  logic             unused_bits;

  // register fields rs/rt/rd/shamt play no part here
  assign unused_bits = ^i_datain[25:6];

  assign i_ready = (state_q == IDLE);
  assign go      = i_valid && i_ready;
  assign o_done  = done_q;
  assign c       = c_q;
  assign c_valid = cv_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign zon     = zon_q;

  // instruction decode and operand magnitudes
  always_comb begin
    op_md   = 1'b0;
    op_mfhi = 1'b0;
    op_mflo = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    if (i_datain[31:26] == 6'd0) begin
      unique case (i_datain[5:0])
        F_MULT, F_MULTU,
        F_DIV, F_DIVU: op_md   = 1'b1;
        F_MFHI:        op_mfhi = 1'b1;
        F_MFLO:        op_mflo = 1'b1;
        F_MTHI:        op_mthi = 1'b1;
        F_MTLO:        op_mtlo = 1'b1;
        default:       ;
      endcase
    end
    sgn_op = op_md && !i_datain[0];
    s1     = sgn_op && gr1[WIDTH-1];
    s2     = sgn_op && gr2[WIDTH-1];
    mag1   = s1 ? ('0 - gr1) : gr1;
    mag2   = s2 ? ('0 - gr2) : gr2;
  end

  // one radix-2 step of each datapath
  always_comb begin
    mul_sum = {1'b0, acc_q}
            + (mq_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {acc_q, mq_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_df  = div_sh[WIDTH-1:0] - b_q;
  end

  // sign fix-up of magnitudes and flag generation
  always_comb begin
    prod = {acc_q, mq_q};
    if (qneg_q) prod = '0 - prod;
    quo = qneg_q ? ('0 - mq_q) : mq_q;
    rem = rneg_q ? ('0 - acc_q) : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_q) begin
      if (b_q == '0) begin
        res_hi = a_raw_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
    res_zon[2] = (res_hi == '0) && (res_lo == '0);
    res_zon[1] = div_q && (b_q == '0);
    res_zon[0] = div_q ? res_lo[WIDTH-1]
                       : res_hi[WIDTH-1];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go && op_md) state_d = CALC;
      CALC: if (cnt_q == CW'(WIDTH-1))
              state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand capture and iterative datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      a_raw_q <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
    end else if (go && op_md) begin
      cnt_q   <= '0;
      div_q   <= i_datain[1];
      qneg_q  <= s1 ^ s2;
      rneg_q  <= s1;
      a_raw_q <= gr1;
      b_q     <= mag2;
      acc_q   <= '0;
      mq_q    <= mag1;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + CW'(1);
      if (div_q) begin
        acc_q <= div_ge ? div_df
                        : div_sh[WIDTH-1:0];
        mq_q  <= {mq_q[WIDTH-2:0], div_ge};
      end else begin
        acc_q <= mul_sum[WIDTH:1];
        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

  // architectural HI/LO/zon, move results and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      c_q    <= '0;
      zon_q  <= '0;
      done_q <= 1'b0;
      cv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cv_q   <= 1'b0;
      if (state_q == FIN) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        zon_q  <= res_zon;
        done_q <= 1'b1;
      end else if (go) begin
        unique case (1'b1)
          op_mfhi: begin
            c_q  <= hi_q;
            cv_q <= 1'b1;
          end
          op_mflo: begin
            c_q  <= lo_q;
            cv_q <= 1'b1;
          end
          op_mthi: hi_q <= gr1;
          op_mtlo: lo_q <= gr1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized scoreboard bench for mdu_seq
// (WIDTH=32) plus directed checks on a WIDTH=8 instance.
module tb_mdu_seq;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  zon;
    logic [63:0] t;
  } dexp_t;

  typedef struct packed {
    logic [31:0] v;
    logic [63:0] t;
  } cexp_t;

  logic        clk, rst_n;
  logic        vld, rdy, done, cv;
  logic [31:0] word, g1, g2, c, hi, lo;
  logic [2:0]  zon;
  logic        v8, rdy8, done8, cv8;
  logic [31:0] w8;
  logic [7:0]  a8, b8, c8, hi8, lo8;
  logic [2:0]  zon8;

  int tests = 0;
  int fails = 0;

  dexp_t done_q[$];
  cexp_t c_q[$];
  dexp_t de;
  cexp_t ce;
  logic [31:0] m_hi, m_lo;
  logic [2:0]  m_zon;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(vld), .i_ready(rdy),
    .i_datain(word), .gr1(g1), .gr2(g2),
    .o_done(done), .c(c), .c_valid(cv),
    .hi(hi), .lo(lo), .zon(zon)
  );

  mdu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(v8), .i_ready(rdy8),
    .i_datain(w8), .gr1(a8), .gr2(b8),
    .o_done(done8), .c(c8), .c_valid(cv8),
    .hi(hi8), .lo(lo8), .zon(zon8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on w-bit values
  // returns {zon, hi, lo}
  function automatic logic [66:0] ref_md(
      input int w, input logic [5:0] f,
      input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, pu, h, l;
    longint sa, sb;
    logic [31:0] rh, rl;
    logic z1;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w)
                : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w)
                : longint'(b);
    z1 = 1'b0;
    pu = '0;
    h  = '0;
    l  = '0;
    if (f == 6'h18 || f == 6'h19) begin
      if (f == 6'h18) pu = 64'(sa * sb);
      else            pu = 64'(a) * 64'(b);
      h = pu >> w;
      l = pu;
    end else if (b == 32'd0) begin
      h  = 64'(a);
      l  = mask;
      z1 = 1'b1;
    end else if (f == 6'h1A) begin
      h = 64'(sa % sb);
      l = 64'(sa / sb);
    end else begin
      h = 64'(a % b);
      l = 64'(a / b);
    end
    h &= mask;
    l &= mask;
    rh = h[31:0];
    rl = l[31:0];
    return {(rh == 0 && rl == 0), z1,
            (f[1] ? rl[w-1] : rh[w-1]), rh, rl};
  endfunction

  // expected effect of an accepted instruction
  task automatic apply(input logic [5:0] op,
                       input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input time t);
    logic [66:0] r;
    if (op != 6'd0) return;
    case (f)
      6'h18, 6'h19, 6'h1A, 6'h1B: begin
        r = ref_md(32, f, a, b);
        m_zon = r[66:64];
        m_hi  = r[63:32];
        m_lo  = r[31:0];
        done_q.push_back({m_hi, m_lo, m_zon,
                          64'(t + 335)});
      end
      6'h10: c_q.push_back({m_hi, 64'(t + 5)});
      6'h12: c_q.push_back({m_lo, 64'(t + 5)});
      6'h11: m_hi = a;
      6'h13: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [5:0] op,
                       input logic [5:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output time t);
    logic r, ok;
    @(negedge clk);
    vld  = 1'b1;
    word = {op, 20'($urandom), f};
    g1   = a;
    g2   = b;
    ok   = 1'b0;
    for (int n = 0; n < 200; n++) begin
      r = rdy;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    t = $time;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: i_ready low 200 cycles");
    end else begin
      apply(op, f, a, b, t);
    end
  endtask

  // drop i_valid and scramble operands while idle
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b0;
      g1  = $urandom;
      g2  = $urandom;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic run8(input logic [5:0] f,
                      input logic [7:0] a,
                      input logic [7:0] b);
    logic [66:0] r;
    logic ok;
    time t;
    @(negedge clk);
    v8 = 1'b1;
    w8 = {6'd0, 20'($urandom), f};
    a8 = a;
    b8 = b;
    @(posedge clk);
    t = $time;
    @(negedge clk);
    v8 = 1'b0;
    a8 = 8'($urandom);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (done8) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    r = ref_md(8, f, {24'd0, a}, {24'd0, b});
    chk("w8_done_seen", 64'(ok), 64'd1);
    chk("w8_latency", 64'($time - t), 64'd95);
    chk("w8_hi", 64'(hi8), 64'(r[39:32]));
    chk("w8_lo", 64'(lo8), 64'(r[7:0]));
    chk("w8_zon", 64'(zon8), 64'(r[66:64]));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: o_done=1 none pending");
        end else begin
          de = done_q.pop_front();
          chk("done_hi", 64'(hi), 64'(de.hi));
          chk("done_lo", 64'(lo), 64'(de.lo));
          chk("done_zon", 64'(zon), 64'(de.zon));
          chk("done_time", 64'($time), de.t);
        end
      end
      if (cv) begin
        if (c_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL cv_unexpected: c_valid=1 none pending");
        end else begin
          ce = c_q.pop_front();
          chk("c_val", 64'(c), 64'(ce.v));
          chk("c_time", 64'($time), ce.t);
        end
      end
    end
  end

  initial begin
    time t1, t2;
    int k;
    logic [5:0] f;
    m_hi = '0;
    m_lo = '0;
    m_zon = '0;
    vld = 1'b0; word = '0; g1 = '0; g2 = '0;
    v8 = 1'b0; w8 = '0; a8 = '0; b8 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    chk("rst_zon", 64'(zon), 64'd0);
    chk("rst_pulses", 64'({done, cv}), 64'd0);
    chk("rst_ready", 64'(rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 6'h18, 32'hFFFF_FFFF, 32'h1, t1);
    issue(0, 6'h19, 32'hD, 32'h1, t2);
    chk("b2b_accept", 64'(t2 - t1), 64'd340);
    issue(0, 6'h1A, 32'hFFFF_FFE1, 32'h11, t1);
    issue(0, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, t1);
    issue(0, 6'h1B, 32'hD, 32'h0, t1);
    issue(0, 6'h18, 32'h1234_5679, 32'hFEDC_BA99, t1);
    idle(5);
    issue(0, 6'h12, $urandom, $urandom, t2);
    chk("mflo_interlock", 64'(t2 - t1), 64'd340);
    issue(0, 6'h11, 32'h1234_5678, $urandom, t1);
    idle(2);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_zon", 64'(zon), 64'(m_zon));

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      f = 6'h18 + 6'($urandom_range(0, 3));
      if (k <= 5)
        issue(0, f, pick(), pick(), t1);
      else if (k == 6)
        issue(0, ($urandom_range(0, 1) != 0)
                 ? 6'h10 : 6'h12, pick(), pick(), t1);
      else if (k == 7)
        issue(0, ($urandom_range(0, 1) != 0)
                 ? 6'h11 : 6'h13, pick(), pick(), t1);
      else if (k == 8)
        issue(6'($urandom_range(1, 63)), f,
              pick(), pick(), t1);
      else
        issue(0, 6'($urandom_range(0, 15)),
              pick(), pick(), t1);
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 4));
    end
    idle(40);
    chk("final_hi", 64'(hi), 64'(m_hi));
    chk("final_lo", 64'(lo), 64'(m_lo));
    chk("final_zon", 64'(zon), 64'(m_zon));

    issue(0, 6'h13, 32'hA5A5_A5A5, 32'h0, t1);
    issue(0, 6'h12, 32'h0, 32'h0, t1);
    issue(0, 6'h19, 32'h3, 32'h5, t1);
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_c", 64'(c), 64'd0);
    chk("midrst_zon", 64'(zon), 64'd0);
    chk("midrst_ready", 64'(rdy), 64'd1);
    done_q.delete();
    m_hi = '0;
    m_lo = '0;
    m_zon = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    chk("post_rst_hi", 64'(hi), 64'd0);
    chk("post_rst_lo", 64'(lo), 64'd0);

    run8(6'h18, 8'hFF, 8'h01);
    run8(6'h1A, 8'h80, 8'hFF);
    run8(6'h1B, 8'h0D, 8'h00);
    for (int i = 0; i < 12; i++)
      run8(6'h18 + 6'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom));

    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    chk("c_q_empty", 64'(c_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers. It is the parametrised sequential successor of the combinational ALU's mult/multu/div/divu path. It decodes the same 32-bit MIPS instruction word, runs a radix-2 iterative shift-add or restoring-divide datapath of WIDTH bits, and serves mfhi/mflo/mthi/mtlo. It sits beside the ALU in the execute stage and stalls the issue logic through a valid/ready handshake.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=4); instruction word stays 32 bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  instruction/operands valid
i_ready  out  1  unit can accept; equals (state==IDLE)
i_datain  in  32  instruction word
gr1  in  WIDTH  rs operand
gr2  in  WIDTH  rt operand
o_done  out  1  one-cycle pulse: mult/div result written to HI/LO
c  out  WIDTH  mfhi/mflo result
c_valid  out  1  one-cycle pulse: c valid
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
zon  out  3  flags: [2] zero (HI==0 && LO==0), [1] divide-by-zero, [0] negative

Behaviour:
- Decode: opcode=i_datain[31:26], func=i_datain[5:0]. opcode 0 with func 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x12 mflo, 0x11 mthi, 0x13 mtlo. Any other word is accepted and ignored, with no state change and no pulses.
- Accept: on a rising edge with i_valid && i_ready. gr1/gr2/func are captured at that edge, so later input changes have no effect.
- States: IDLE -> CALC on accepting mult/multu/div/divu. CALC runs exactly WIDTH iterations, one per edge, then -> FIN. FIN -> IDLE after one edge.
- FIN edge: HI/LO/zon written, o_done=1 for the following cycle. i_ready is high in that same cycle, so back-to-back ops are allowed.
- Latency: HI/LO update WIDTH+1 edges after the accept edge. Latency is fixed, including divide-by-zero.
- Signed ops:
  - Operate on magnitudes.
  - Product sign = s1^s2.
  - Quotient sign = s1^s2; remainder sign = s1 (truncation toward zero).
  - Mult result {HI,LO} is the 2*WIDTH product.
  - Div result: LO = quotient, HI = remainder.
- Overflow case: signed MIN / -1 gives LO=MIN (wraps), HI=0, zon[1]=0.
- Divide by zero (div or divu): HI=gr1 as captured, LO=all ones, zon[1]=1.
- zon[0]: HI[WIDTH-1] for mult/multu; LO[WIDTH-1] for div/divu.
- zon hold: zon holds until the next FIN; mthi/mtlo do not change zon.
- mfhi/mflo:
  - Accepted only in IDLE.
  - On the accept edge, c is loaded from HI or LO and c_valid=1 for one cycle.
  - c holds its value afterwards.
  - While busy, i_ready=0 stalls the request (interlock); upstream must hold i_valid and the word.
- mthi/mtlo: in IDLE, on the accept edge HI/LO is loaded from gr1. No pulses.
- Reset (asynchronous, any time including mid-CALC):
  - State=IDLE; iteration counter, hi, lo, c, zon cleared to 0; o_done=0, c_valid=0.
  - Any in-flight operation is discarded.
  - i_ready=1 while rst_n=0 and after release.
- i_valid while not ready: ignored; no queuing.

Test Plan:
- mult, gr1=0xFFFFFFFF, gr2=0x00000001 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFF, zon=001, o_done one-cycle pulse.
- multu, gr1=0x0000000D, gr2=0x00000001 -> HI=0x00000000, LO=0x0000000D, zon=000. A second multu issued in the o_done cycle is accepted.
- div, gr1=0xFFFFFFE1 (-31), gr2=0x00000011 (17) -> LO=0xFFFFFFFF, HI=0xFFFFFFF2, zon=001. Also: div with gr1=0x80000000, gr2=0xFFFFFFFF -> LO=0x80000000, HI=0, zon=001.
- divu, gr1=0x0000000D, gr2=0 -> HI=0x0000000D, LO=0xFFFFFFFF, zon=011, latency 33 edges.
- mflo presented 5 cycles into a mult -> i_ready=0 until FIN. It is accepted in the o_done cycle, giving c equal to the new LO and a c_valid pulse. A subsequent mthi with gr1=0x12345678 gives HI=0x12345678, zon unchanged.
- rst_n pulsed low mid-CALC -> immediately hi=lo=c=0, zon=000, i_ready=1, and no o_done follows. Repeat the first case with WIDTH=8 (gr1=0xFF, gr2=0x01): HI=0xFF, LO=0xFF after 9 edges.
